pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
// - Central stall/flush sequencer for the 5-stage pipeline; drives the hold/flush controls of PC, IF_ID, ID_EX, EX_MEM.
// - Resolves three events: load-use hazard (1-cycle bubble), data-memory wait (full freeze) and taken branch/jump (wrong-path flush).
// - Keeps a registered FSM, a memory-wait watchdog and a saturating stall-cycle performance counter.
// PARAMETERS
// - MEM_TIMEOUT   16  max dmem wait cycles before mem_timeout is raised (>=2)
// - CNT_W         32  width of stall_cycles counter
// PORTS
// - clk                   in   1      system clock, rising edge
// - reset                 in   1      asynchronous, active-high
// - ID_rs1, ID_rs2        in   5      source regs of instruction in ID
// - ID_EX_memread         in   1      instruction in EX is a load
// - ID_EX_rd              in   5      dest reg of instruction in EX
// - EX_branch_taken       in   1      conditional branch in EX resolved taken
// - ID_EX_unconditional_jmp in 1      jal/jalr in EX
// - EX_MEM_memread        in   1      load in MEM stage
// - EX_MEM_memwrite       in   1      store in MEM stage
// - dmem_ready            in   1      data memory completes access this cycle
// - PC_stall              out  1      hold PC
// - IF_ID_stall           out  1      hold IF_ID
// - IF_ID_flush           out  1      load NOP into IF_ID
// - EX_stall              out  1      hold ID_EX (drives ID_EX_reg.EX_stall)
// - ID_EX_flush           out  1      load bubble (all ctrl=0) into ID_EX
// - MEM_stall             out  1      hold EX_MEM, suppress MEM_WB write
// - mem_timeout           out  1      sticky: a dmem access exceeded MEM_TIMEOUT
// - stall_cycles          out  CNT_W  count of cycles with PC_stall=1, saturating
// BEHAVIOUR
// - Reset: state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0; all control outputs forced 0 while reset high.
// - Control outputs combinational from registered state + current inputs (same-cycle effect); state/counters registered.
// - mem_busy = (EX_MEM_memread|EX_MEM_memwrite) & ~dmem_ready.
// - redirect = EX_branch_taken | ID_EX_unconditional_jmp.
// - load_use = ID_EX_memread & ID_EX_rd!=0 & (ID_EX_rd==ID_rs1 | ID_EX_rd==ID_rs2).
// - Priority each cycle: mem_busy > redirect > load_use.
// - RUN:
//   - mem_busy -> assert PC_stall, IF_ID_stall, EX_stall, MEM_stall; next MEM_WAIT, wait_cnt=1.
//   - else redirect -> IF_ID_flush, ID_EX_flush; next FLUSH.
//   - else load_use -> PC_stall, IF_ID_stall, ID_EX_flush; stay RUN.
//   - else all 0.
// - MEM_WAIT:
//   - ~dmem_ready -> freeze set as above; wait_cnt++ (saturate at MEM_TIMEOUT); when wait_cnt==MEM_TIMEOUT-1 and still not ready, set mem_timeout next edge.
//   - dmem_ready -> freeze released this cycle, outputs evaluated by RUN rules (redirect/load_use honoured); next RUN (or FLUSH if redirect), wait_cnt=0.
// - FLUSH (1 cycle): load_use ignored (ID holds wrong-path instr); mem_busy still freezes -> MEM_WAIT; redirect -> flush again, stay FLUSH; else -> RUN.
// - Freeze and flush never co-asserted on the same register: EX_stall=1 implies ID_EX_flush=0; IF_ID_stall=1 implies IF_ID_flush=0.
// - Register-zero rule: ID_EX_rd==0 never causes load_use.
// - mem_timeout cleared only by reset; FSM continues to wait regardless.
// - stall_cycles += PC_stall each cycle; holds at 2^CNT_W-1.
// - Reset mid-MEM_WAIT: immediate return to RUN, outputs 0, counters cleared.
// STRUCTURE
// - pipeline_ctrl_defs.vh (shared): state encodings ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_FLUSH=2'd2; NOP/bubble constants reused by IF_ID/ID_EX regs.
// - Sub-module load_use_detector (combinational compare of ID_rs1/ID_rs2 vs ID_EX_rd, gated by ID_EX_memread).
// - Top: FSM, priority mux, wait_cnt, mem_timeout flop, stall_cycles counter.
// TESTING
// - Load-use: ID_EX_memread=1, ID_EX_rd=5, ID_rs2=5 -> 1 cycle PC_stall=IF_ID_stall=ID_EX_flush=1, EX_stall=0; stall_cycles=1.
// - rd=x0: ID_EX_memread=1, ID_EX_rd=0, ID_rs1=0 -> all outputs 0.
// - Mem wait: EX_MEM_memread=1, dmem_ready low 3 cycles then high -> PC/IF_ID/EX/MEM stall=1 for 3 cycles, 0 on ready cycle; state RUN after.
// - Timeout: dmem_ready low 20 cycles, MEM_TIMEOUT=16 -> mem_timeout=1 from cycle 16 on, stays 1 after ready; wait_cnt saturates.
// - Redirect vs load_use same cycle: EX_branch_taken=1 and load_use=1 -> IF_ID_flush=ID_EX_flush=1, PC_stall=0; next cycle load_use ignored (FLUSH).
// - Reset asserted during MEM_WAIT -> outputs 0 asynchronously, stall_cycles=0, mem_timeout=0, RUN on release.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// rtl/pipeline_stall_ctrl_pkg.sv - shared state encodings, control bundle and bubble constants
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic ex_stall;
        logic id_ex_flush;
        logic mem_stall;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE   = 6'b000000;
    localparam ctrl_t CTRL_FREEZE = 6'b110101;
    localparam ctrl_t CTRL_FLUSH  = 6'b001010;
    localparam ctrl_t CTRL_BUBBLE = 6'b110010;

    // Values loaded by IF_ID / ID_EX when flushed: addi x0,x0,0 and an all-zero control word.
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] BUBBLE_CTRL = 32'h0000_0000;

    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_load_use_detector.sv
// rtl/pipeline_stall_ctrl_load_use_detector.sv - combinational load-use hazard compare
module load_use_detector
    import pipeline_stall_ctrl_pkg::*;
(
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic [4:0] i_id_ex_rd,
    input  logic       i_id_ex_memread,
    output logic       o_load_use
);

    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1  = reg_match(i_id_ex_rd, i_id_rs1);
    assign w_hit_rs2  = reg_match(i_id_ex_rd, i_id_rs2);
    assign o_load_use = i_id_ex_memread & (w_hit_rs1 | w_hit_rs2);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - stall/flush sequencer with dmem watchdog and stall-cycle counter
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_ex_memread,
    input  logic [4:0]       i_id_ex_rd,
    input  logic             i_ex_branch_taken,
    input  logic             i_id_ex_unconditional_jmp,
    input  logic             i_ex_mem_memread,
    input  logic             i_ex_mem_memwrite,
    input  logic             i_dmem_ready,
    output logic             o_pc_stall,
    output logic             o_if_id_stall,
    output logic             o_if_id_flush,
    output logic             o_ex_stall,
    output logic             o_id_ex_flush,
    output logic             o_mem_stall,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cycles
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WC_TRIG = WC_W'(MEM_TIMEOUT - 1);

    state_t          r_state;
    logic [WC_W-1:0] r_wait_cnt;
    logic            r_mem_timeout;
    logic [CNT_W-1:0] r_stall_cycles;

    state_t w_next;
    ctrl_t  w_ctrl;
    ctrl_t  w_out;
    logic   w_mem_busy;
    logic   w_redirect;
    logic   w_load_use;

    load_use_detector u_load_use (
        .i_id_rs1        (i_id_rs1),
        .i_id_rs2        (i_id_rs2),
        .i_id_ex_rd      (i_id_ex_rd),
        .i_id_ex_memread (i_id_ex_memread),
        .o_load_use      (w_load_use)
    );

    assign w_mem_busy = (i_ex_mem_memread | i_ex_mem_memwrite) & ~i_dmem_ready;
    assign w_redirect = i_ex_branch_taken | i_id_ex_unconditional_jmp;

    always_comb begin
        w_ctrl = CTRL_NONE;
        w_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_mem_busy) begin
                    w_ctrl = CTRL_FREEZE;
                    w_next = ST_MEM_WAIT;
                end else if (w_redirect) begin
                    w_ctrl = CTRL_FLUSH;
                    w_next = ST_FLUSH;
                end else if (w_load_use) begin
                    w_ctrl = CTRL_BUBBLE;
                    w_next = ST_RUN;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                // Release cycle falls through to the normal RUN priorities.
                if (!i_dmem_ready) begin
                    w_ctrl = CTRL_FREEZE;
                    w_next = ST_MEM_WAIT;
                end else if (w_redirect) begin
                    w_ctrl = CTRL_FLUSH;
                    w_next = ST_FLUSH;
                end else if (w_load_use) begin
                    w_ctrl = CTRL_BUBBLE;
                    w_next = ST_RUN;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // ID holds a wrong-path instruction, so its load-use hazard is meaningless.
                if (w_mem_busy) begin
                    w_ctrl = CTRL_FREEZE;
                    w_next = ST_MEM_WAIT;
                end else if (w_redirect) begin
                    w_ctrl = CTRL_FLUSH;
                    w_next = ST_FLUSH;
                end else begin
                    w_next = ST_RUN;
                end
            end
            default: begin
                w_next = ST_RUN;
            end
        endcase
    end

    assign w_out = i_reset ? CTRL_NONE : w_ctrl;

    assign o_pc_stall     = w_out.pc_stall;
    assign o_if_id_stall  = w_out.if_id_stall;
    assign o_if_id_flush  = w_out.if_id_flush;
    assign o_ex_stall     = w_out.ex_stall;
    assign o_id_ex_flush  = w_out.id_ex_flush;
    assign o_mem_stall    = w_out.mem_stall;
    assign o_mem_timeout  = r_mem_timeout;
    assign o_stall_cycles = r_stall_cycles;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_RUN;
            r_wait_cnt     <= '0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_next;

            if (w_next == ST_MEM_WAIT) begin
                if (r_state != ST_MEM_WAIT) begin
                    r_wait_cnt <= WC_W'(1);
                end else if (r_wait_cnt != WC_MAX) begin
                    r_wait_cnt <= r_wait_cnt + WC_W'(1);
                end
            end else begin
                r_wait_cnt <= '0;
            end

            if (r_state == ST_MEM_WAIT && !i_dmem_ready && r_wait_cnt == WC_TRIG) begin
                r_mem_timeout <= 1'b1;
            end

            if (w_out.pc_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - table, directed and randomized checks of pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

    localparam int MT = 16;
    localparam int CW = 8;
    localparam logic [5:0] E_NONE   = 6'b000000;
    localparam logic [5:0] E_FREEZE = 6'b110101;
    localparam logic [5:0] E_FLUSH  = 6'b001010;
    localparam logic [5:0] E_BUB    = 6'b110010;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1, rs2, rd;
    logic          ld, br, jmp, mrd, mwr, rdy;
    logic          pc_st, ifid_st, ifid_fl, ex_st, idex_fl, mem_st, tmo;
    logic [CW-1:0] stalls;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .i_clk                     (clk),
        .i_reset                   (rst),
        .i_id_rs1                  (rs1),
        .i_id_rs2                  (rs2),
        .i_id_ex_memread           (ld),
        .i_id_ex_rd                (rd),
        .i_ex_branch_taken         (br),
        .i_id_ex_unconditional_jmp (jmp),
        .i_ex_mem_memread          (mrd),
        .i_ex_mem_memwrite         (mwr),
        .i_dmem_ready              (rdy),
        .o_pc_stall                (pc_st),
        .o_if_id_stall             (ifid_st),
        .o_if_id_flush             (ifid_fl),
        .o_ex_stall                (ex_st),
        .o_id_ex_flush             (idex_fl),
        .o_mem_stall               (mem_st),
        .o_mem_timeout             (tmo),
        .o_stall_cycles            (stalls)
    );

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       ld, br, jmp, mrd, mwr, rdy;
        logic [5:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                                input logic l, input logic bt, input logic j,
                                input logic mr, input logic mw, input logic ry,
                                input logic [5:0] e);
        vec_t v;
        v.rs1 = a; v.rs2 = b; v.rd = d; v.ld = l; v.br = bt; v.jmp = j;
        v.mrd = mr; v.mwr = mw; v.rdy = ry; v.exp = e;
        return v;
    endfunction

    function automatic logic [5:0] outs();
        return {pc_st, ifid_st, ifid_fl, ex_st, idex_fl, mem_st};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; ld = v.ld; br = v.br; jmp = v.jmp;
        mrd = v.mrd; mwr = v.mwr; rdy = v.rdy;
    endtask

    task automatic cyc(input string name, input vec_t v);
        apply(v);
        @(negedge clk);
        chk(name, 32'(outs()), 32'(v.exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_NONE));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t tbl[12];
    vec_t idle;

    // Reference model state: what happened on the previous cycle.
    logic m_frozen, m_flushed, m_to;
    int   m_run, m_stalls;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_NONE);
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_NONE);
        tbl[1]  = mk(3, 5, 5, 1, 0, 0, 0, 0, 1, E_BUB);
        tbl[2]  = mk(0, 4, 0, 1, 0, 0, 0, 0, 1, E_NONE);
        tbl[3]  = mk(7, 1, 7, 0, 0, 0, 0, 0, 1, E_NONE);
        tbl[4]  = mk(7, 1, 7, 1, 0, 0, 0, 0, 1, E_BUB);
        tbl[5]  = mk(1, 2, 3, 0, 1, 0, 0, 0, 1, E_FLUSH);
        tbl[6]  = mk(1, 2, 3, 0, 0, 1, 0, 0, 1, E_FLUSH);
        tbl[7]  = mk(9, 2, 9, 1, 1, 0, 0, 0, 1, E_FLUSH);
        tbl[8]  = mk(1, 2, 3, 0, 0, 0, 1, 0, 0, E_FREEZE);
        tbl[9]  = mk(9, 2, 9, 1, 1, 0, 0, 1, 0, E_FREEZE);
        tbl[10] = mk(1, 2, 3, 0, 0, 0, 1, 0, 1, E_NONE);
        tbl[11] = mk(4, 6, 6, 1, 0, 0, 0, 1, 1, E_BUB);

        rst = 1'b1;
        apply(idle);
        #1;
        chk("reset_outs", 32'(outs()), 32'(E_NONE));
        chk("reset_stalls", 32'(stalls), 0);
        chk("reset_timeout", 32'(tmo), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_reset();
            cyc($sformatf("table_%0d", i), tbl[i]);
        end

        // Single load-use bubble counted once.
        do_reset();
        cyc("lu_bubble", mk(3, 5, 5, 1, 0, 0, 0, 0, 1, E_BUB));
        cyc("lu_after", idle);
        chk("lu_stalls", 32'(stalls), 1);

        // Three-cycle dmem wait, released on the ready cycle.
        do_reset();
        for (int i = 0; i < 3; i++) cyc($sformatf("wait_%0d", i), mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_FREEZE));
        cyc("wait_release", mk(0, 0, 0, 0, 0, 0, 1, 0, 1, E_NONE));
        cyc("wait_run", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE));
        chk("wait_stalls", 32'(stalls), 3);

        // Watchdog: mem_timeout visible from cycle 16 of a 20-cycle wait and sticky afterwards.
        do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_FREEZE));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("tmo_outs_%0d", i), 32'(outs()), 32'(E_FREEZE));
            chk($sformatf("tmo_flag_%0d", i), 32'(tmo), (i >= 16) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        cyc("tmo_release", mk(0, 0, 0, 0, 0, 0, 1, 0, 1, E_NONE));
        chk("tmo_sticky", 32'(tmo), 1);

        // Redirect beats load-use; the following FLUSH cycle ignores load-use.
        cyc("redir_lu", mk(9, 2, 9, 1, 1, 0, 0, 0, 1, E_FLUSH));
        cyc("flush_ignores_lu", mk(9, 2, 9, 1, 0, 0, 0, 0, 1, E_NONE));
        cyc("run_honours_lu", mk(9, 2, 9, 1, 0, 0, 0, 0, 1, E_BUB));
        chk("tmo_still_set", 32'(tmo), 1);

        // Asynchronous reset in the middle of a dmem wait.
        cyc("mw_enter", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_FREEZE));
        cyc("mw_hold", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_FREEZE));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outs", 32'(outs()), 32'(E_NONE));
        chk("rst_async_stalls", 32'(stalls), 0);
        chk("rst_async_timeout", 32'(tmo), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("rst_back_in_run", mk(9, 2, 9, 1, 0, 0, 0, 0, 0, E_BUB));

        // Stall counter saturates at 2^CW-1.
        do_reset();
        apply(mk(5, 0, 5, 1, 0, 0, 0, 0, 1, E_BUB));
        repeat (300) @(posedge clk);
        #1;
        chk("stalls_saturate", 32'(stalls), 32'((1 << CW) - 1));

        // Randomized run against the reference model.
        do_reset();
        m_frozen = 1'b0; m_flushed = 1'b0; m_to = 1'b0; m_run = 0; m_stalls = 0;
        for (int i = 0; i < 3000; i++) begin
            logic       freeze, lu;
            logic [5:0] e;
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            ld  = ($urandom_range(0, 1) == 1);
            br  = ($urandom_range(0, 5) == 0);
            jmp = ($urandom_range(0, 9) == 0);
            mrd = ($urandom_range(0, 3) == 0);
            mwr = ($urandom_range(0, 5) == 0);
            rdy = ((i % 500) >= 100 && (i % 500) < 120) ? 1'b0 : ($urandom_range(0, 9) < 7);

            freeze = m_frozen ? !rdy : ((mrd | mwr) & !rdy);
            lu     = ld && (rd != 0) && (rd == rs1 || rd == rs2);
            if (freeze)                  e = E_FREEZE;
            else if (br | jmp)           e = E_FLUSH;
            else if (lu && !m_flushed)   e = E_BUB;
            else                         e = E_NONE;

            @(negedge clk);
            chk($sformatf("rnd_outs_%0d", i), 32'(outs()), 32'(e));
            chk($sformatf("rnd_tmo_%0d", i), 32'(tmo), 32'(m_to));
            chk($sformatf("rnd_stalls_%0d", i), 32'(stalls), 32'(m_stalls));
            @(posedge clk);
            #1;
            m_frozen  = freeze;
            m_flushed = (e == E_FLUSH);
            m_run     = freeze ? m_run + 1 : 0;
            if (m_run >= MT) m_to = 1'b1;
            if (e[5] && m_stalls < (1 << CW) - 1) m_stalls++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
